// File: rtl/mem_io_if.sv
// Byte-serial CPU memory bus: one byte read or write per cycle from the initiator,
// registered read data and FIFO back-pressure from the responder.
interface mem_io_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;

  modport master (output mem_a, mem_wr, mem_wdata, input  mem_rdata, io_buffer_full);
  modport slave  (input  mem_a, mem_wr, mem_wdata, output mem_rdata, io_buffer_full);
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM plus an IO window at addr[17:16]==2'b11 holding a
// UART TX FIFO (8N1 serialiser), a status register and a sticky halt register.
module mem_io_responder #(
  parameter int ADDR_WIDTH   = 17,
  parameter     INIT_FILE    = "",
  parameter int FIFO_DEPTH   = 16,
  parameter int FULL_MARGIN  = 2,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  mem_io_if.slave  bus,
  output logic     uart_tx,
  output logic     tx_busy,
  output logic     halt,
  output logic     overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0] ram [2**ADDR_WIDTH];

  // Address decode: only bits 17:0 matter, the rest of the bus address is ignored.
  logic [17:0]           a;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  io, io_tx, io_st;
  logic                  unused_addr;

  assign a           = bus.mem_a[17:0];
  assign idx         = bus.mem_a[ADDR_WIDTH-1:0];
  assign io          = (a[17:16] == 2'b11);
  assign io_tx       = io && (a == 18'h30000);
  assign io_st       = io && (a == 18'h30004);
  assign unused_addr = ^bus.mem_a;

  logic [7:0] rdata_q;
  logic       full_q;
  assign bus.mem_rdata      = rdata_q;
  assign bus.io_buffer_full = full_q;

  always_ff @(posedge clk)
    if (bus.mem_wr && !io) ram[idx] <= bus.mem_wdata;

  // Read-before-write: a write cycle returns the byte that was there before.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (io) rdata_q <= io_st ? {6'b0, overflow, full_q} : 8'h00;
    else         rdata_q <= ram[idx];
  end

  // TX FIFO
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push_req, push, pop;
  state_t        state;

  assign push_req  = bus.mem_wr && io_tx;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign push      = push_req && ((count < CW'(FIFO_DEPTH)) || pop);
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= bus.mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      overflow <= 1'b0;
      halt     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      // Margin leaves room for stores the initiator already has in flight.
      full_q <= (count_nxt >= CW'(FIFO_DEPTH - FULL_MARGIN));
      if (push_req && !push)      overflow <= 1'b1;
      if (bus.mem_wr && io_st)    halt     <= 1'b1;
    end
  end

  // UART 8N1 serialiser; uart_tx and tx_busy are registered alongside the state.
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_end;

  assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift   <= fifo[rd_ptr];
            state   <= S_START;
            uart_tx <= 1'b0;
            tx_busy <= 1'b1;
            baud    <= '0;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            uart_tx <= shift[0];
          end else baud <= baud + 1'b1;
        end
        S_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              uart_tx <= shift[1];
            end
          end else baud <= baud + 1'b1;
        end
        S_STOP: begin
          if (baud_end) begin
            baud    <= '0;
            state   <= S_IDLE;
            tx_busy <= 1'b0;
          end else baud <= baud + 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus random traffic, all checked each
// cycle against a queue/array model of the bus, FIFO and UART frame timing.
module tb_mem_io_responder;
  localparam int DEPTH = 16, MARGIN = 2, CPB = 4;
  localparam logic [31:0] IDLE_A = 32'h30008;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx, tx_busy, halt, overflow;

  mem_io_if bus();

  mem_io_responder #(.ADDR_WIDTH(17), .INIT_FILE(""), .FIFO_DEPTH(DEPTH),
                     .FULL_MARGIN(MARGIN), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .halt(halt), .overflow(overflow));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] q [$];
  bit         m_on = 0, m_halt, m_ovf, m_full, m_rd_ok;
  logic [7:0] m_rd, m_cur;
  int         fpos = -1;   // cycle index within the current 10-bit frame, -1 when idle

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by the clock edge that just consumed the held inputs.
  task automatic model_step();
    logic [17:0] a;
    logic        io, pop;
    int          idx;
    a   = bus.mem_a[17:0];
    io  = (a[17:16] == 2'b11);
    idx = int'(bus.mem_a[16:0]);
    if (rst) begin
      q.delete();
      m_halt = 0; m_ovf = 0; m_full = 0; m_rd = 8'h00; m_rd_ok = 1; fpos = -1; m_on = 1;
      return;
    end
    if (!m_on) return;
    if (io) begin
      m_rd = (a == 18'h30004) ? {6'b0, m_ovf, m_full} : 8'h00;
      m_rd_ok = 1;
    end else if (ram_m.exists(idx)) begin
      m_rd = ram_m[idx]; m_rd_ok = 1;
    end else m_rd_ok = 0;
    pop = (fpos < 0) && (q.size() > 0);
    if (fpos >= 0) begin
      fpos++;
      if (fpos == 10 * CPB) fpos = -1;
    end
    if (pop) begin m_cur = q.pop_front(); fpos = 0; end
    if (bus.mem_wr) begin
      if (!io) ram_m[idx] = bus.mem_wdata;
      else if (a == 18'h30000) begin
        if (q.size() < DEPTH) q.push_back(bus.mem_wdata);
        else m_ovf = 1;
      end else if (a == 18'h30004) m_halt = 1;
    end
    m_full = (q.size() >= DEPTH - MARGIN);
  endtask

  function automatic logic exp_tx();
    int b;
    if (fpos < 0) return 1'b1;
    b = fpos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic compare();
    if (!m_on) return;
    chk("uart_tx",        uart_tx,            exp_tx());
    chk("tx_busy",        tx_busy,            fpos >= 0);
    chk("halt",           halt,               m_halt);
    chk("overflow",       overflow,           m_ovf);
    chk("io_buffer_full", bus.io_buffer_full, m_full);
    if (m_rd_ok) chk("mem_rdata", bus.mem_rdata, m_rd);
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    compare();
  endtask

  task automatic drive(logic [31:0] a, logic wr, logic [7:0] d);
    bus.mem_a = a; bus.mem_wr = wr; bus.mem_wdata = d;
  endtask

  task automatic op(logic [31:0] a, logic wr, logic [7:0] d);
    tick();
    drive(a, wr, d);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    drive(IDLE_A, 1'b0, 8'h00);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] t2v [4];
    logic [9:0] t3p;
    int         w, r, sel;
    logic [31:0] ra;
    t2v = '{8'h11, 8'h22, 8'h33, 8'h44};
    t3p = {1'b1, 8'h55, 1'b0};
    drive(IDLE_A, 1'b0, 8'h00);

    // Reset state
    tick(); tick();
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_tx_busy", tx_busy, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_full", bus.io_buffer_full, 1'b0);
    chk("rst_rdata", bus.mem_rdata, 8'h00);
    rst = 1'b0;

    // T1: write then read back one cycle later
    op(32'h10, 1'b1, 8'hA5);
    op(32'h10, 1'b0, 8'h00);
    op(IDLE_A, 1'b0, 8'h00);
    chk("t1_rdata", bus.mem_rdata, 8'hA5);

    // T2: streaming reads, one new address per cycle
    for (int i = 0; i < 4; i++) op(32'h100 + i, 1'b1, t2v[i]);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i > 0) chk("t2_stream", bus.mem_rdata, t2v[i-1]);
      if (i < 4) drive(32'h100 + i, 1'b0, 8'h00);
      else       drive(IDLE_A, 1'b0, 8'h00);
    end

    // T3: 0x55 frame, 4 cycles per bit
    op(32'h30000, 1'b1, 8'h55);
    op(IDLE_A, 1'b0, 8'h00);
    for (int k = 0; k < 10 * CPB; k++) begin
      tick();
      chk("t3_tx", uart_tx, t3p[k / CPB]);
      chk("t3_busy", tx_busy, 1'b1);
    end
    tick();
    chk("t3_end_busy", tx_busy, 1'b0);
    chk("t3_end_tx", uart_tx, 1'b1);

    // T4: fill the FIFO while the UART is busy, then one more
    op(32'h30000, 1'b1, 8'hC0);
    op(IDLE_A, 1'b0, 8'h00);
    op(IDLE_A, 1'b0, 8'h00);
    op(IDLE_A, 1'b0, 8'h00);
    for (int i = 0; i <= 17; i++) begin
      tick();
      if (i > 0) begin
        chk("t4_full", bus.io_buffer_full, i >= 14);
        chk("t4_ovf", overflow, i >= 17);
      end
      if (i < 17) drive(32'h30000, 1'b1, 8'(i));
      else        drive(32'h30004, 1'b0, 8'h00);
    end
    tick();
    chk("t4_status", bus.mem_rdata, 8'h03);

    // T5: full FIFO, push coinciding with the IDLE pop is accepted
    do_reset();
    op(32'h30000, 1'b1, 8'h81);
    op(IDLE_A, 1'b0, 8'h00);
    op(IDLE_A, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) op(32'h30000, 1'b1, 8'(i + 1));
    op(IDLE_A, 1'b0, 8'h00);
    w = 0;
    while (tx_busy && w < 200) begin tick(); w++; end
    chk("t5_wait_idle", tx_busy, 1'b0);
    drive(32'h30000, 1'b1, 8'hEE);
    tick();
    chk("t5_ovf_simul", overflow, 1'b0);
    chk("t5_full", bus.io_buffer_full, 1'b1);
    drive(32'h30000, 1'b1, 8'hEF);
    tick();
    chk("t5_ovf_after", overflow, 1'b1);
    drive(IDLE_A, 1'b0, 8'h00);

    // T6: halt, then reset mid-frame
    do_reset();
    op(32'h1234, 1'b1, 8'h3C);
    op(32'h30004, 1'b1, 8'h00);
    op(IDLE_A, 1'b0, 8'h00);
    chk("t6_halt", halt, 1'b1);
    op(32'h30000, 1'b1, 8'h5A);
    for (int i = 0; i < 11; i++) op(IDLE_A, 1'b0, 8'h00);
    chk("t6_busy_mid", tx_busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_rst_halt", halt, 1'b0);
    chk("t6_rst_tx", uart_tx, 1'b1);
    chk("t6_rst_busy", tx_busy, 1'b0);
    rst = 1'b0;
    tick(); tick();
    chk("t6_fifo_empty", tx_busy, 1'b0);
    op(32'h1234, 1'b0, 8'h00);
    op(IDLE_A, 1'b0, 8'h00);
    chk("t6_ram_kept", bus.mem_rdata, 8'h3C);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      r = $urandom_range(0, 199);
      rst = (r == 0);
      if (rst) begin
        drive(IDLE_A, 1'b0, 8'h00);
      end else begin
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2, 3: begin
            ra = $urandom() & 32'hFFFC_003F;
            drive(ra, 1'($urandom_range(0, 1)), 8'($urandom()));
          end
          4, 5: begin
            ra = ($urandom() & 32'hFFFC_0000) | 32'h30000;
            drive(ra, $urandom_range(0, 3) == 0, 8'($urandom()));
          end
          6: drive(32'h30004, $urandom_range(0, 15) == 0, 8'($urandom()));
          7, 8: begin
            ra = 32'h30000 | 32'($urandom_range(1, 16'hFFFF));
            drive(ra, 1'($urandom_range(0, 1)), 8'($urandom()));
          end
          default: drive(IDLE_A, 1'b0, 8'h00);
        endcase
      end
    end
    rst = 1'b0;
    drive(IDLE_A, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
